// File: rtl/sb_bus_arbiter.sv
// sb_bus_arbiter: round-robin owner selection for the shared OR'd system bus.
// One master is granted per transaction. The arbiter follows that transaction
// until a slave ends it. A watchdog ends hung transactions with a bus error,
// so a stalled master or slave can never lock up the bus.
//
// Request/grant handshake: a master raises request_i[m] and holds it until its
// transaction completes. grant_o[m] rises one cycle after arbitration. The
// master begins with sb_begin_transaction_i while granted. The grant drops on
// the edge that samples the slave end, a request withdrawal before begin, or a
// watchdog expiry. Every transaction is arbitrated on its own, so there is at
// least one cycle with grant_o == 0 between two grants.
module sb_bus_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int TIMEOUT_WIDTH  = 8,
    parameter int TIMEOUT_CYCLES = 200
) (
    input  logic                   sb_clock_i,
    input  logic                   sb_reset_n_i,
    input  logic [NUM_MASTERS-1:0] request_i,
    input  logic                   sb_begin_transaction_i,
    input  logic                   sb_end_transaction_i,
    input  logic                   sb_error_i,
    output logic [NUM_MASTERS-1:0] grant_o,
    output logic [2:0]             active_master_o,
    output logic                   sb_end_transaction_o,
    output logic                   sb_error_o,
    output logic                   busy_o,
    output logic [7:0]             timeout_count_o,
    output logic [1:0]             dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANTED = 2'd1,
        ST_BUSY    = 2'd2
    } state_t;

    // The watchdog value seen during the last cycle allowed in GRANTED or BUSY.
    localparam logic [TIMEOUT_WIDTH-1:0] WD_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [NUM_MASTERS-1:0]   r_grant;
    logic [NUM_MASTERS-1:0]   w_grant_nxt;
    logic [2:0]               r_active;
    logic [2:0]               w_active_nxt;
    logic [2:0]               r_last;
    logic [2:0]               w_last_nxt;
    logic [TIMEOUT_WIDTH-1:0] r_wd;
    logic [TIMEOUT_WIDTH-1:0] w_wd_nxt;
    logic                     w_timeout;
    logic                     r_tmo_pulse;
    logic [7:0]               r_tmo_count;

    logic                     w_rr_found;
    logic [2:0]               w_rr_winner;
    logic [NUM_MASTERS-1:0]   w_rr_onehot;
    logic                     w_req_held;
    logic                     w_wd_expired;
    logic                     w_unused_error;

    // The slave error belongs to the master that owns the bus. The arbiter
    // never needs it.
    assign w_unused_error = sb_error_i;

    assign w_req_held   = |(request_i & r_grant);
    assign w_wd_expired = (r_wd == WD_LAST);

    // Round-robin search: first requester above r_last, else wrap to the lowest requester.
    always_comb begin
        w_rr_found  = 1'b0;
        w_rr_winner = '0;
        w_rr_onehot = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!w_rr_found && request_i[i] && (i > int'(r_last))) begin
                w_rr_found     = 1'b1;
                w_rr_winner    = 3'(i);
                w_rr_onehot[i] = 1'b1;
            end
        end
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!w_rr_found && request_i[i]) begin
                w_rr_found     = 1'b1;
                w_rr_winner    = 3'(i);
                w_rr_onehot[i] = 1'b1;
            end
        end
    end

    // Next-state logic. Begin and end take priority over a watchdog expiry in the same cycle.
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_active_nxt = r_active;
        w_last_nxt   = r_last;
        w_wd_nxt     = r_wd;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rr_found) begin
                    w_state_nxt  = ST_GRANTED;
                    w_grant_nxt  = w_rr_onehot;
                    w_active_nxt = w_rr_winner;
                    w_last_nxt   = w_rr_winner;
                    w_wd_nxt     = '0;
                end
            end
            ST_GRANTED: begin
                if (sb_begin_transaction_i) begin
                    w_state_nxt = ST_BUSY;
                    w_wd_nxt    = '0;
                end else if (!w_req_held) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
                end else if (w_wd_expired) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
                    w_timeout   = 1'b1;
                end else begin
                    w_wd_nxt = r_wd + 1'b1;
                end
            end
            ST_BUSY: begin
                if (sb_end_transaction_i) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
                end else if (w_wd_expired) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
                    w_timeout   = 1'b1;
                end else begin
                    w_wd_nxt = r_wd + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // State, grant and watchdog registers. Reset abandons any transaction silently.
    always_ff @(posedge sb_clock_i or negedge sb_reset_n_i) begin
        if (!sb_reset_n_i) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_active <= '0;
            r_last   <= 3'(NUM_MASTERS - 1);
            r_wd     <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_active <= w_active_nxt;
            r_last   <= w_last_nxt;
            r_wd     <= w_wd_nxt;
        end
    end

    // One-cycle end/error pulse on expiry, and a saturating count of expiries.
    always_ff @(posedge sb_clock_i or negedge sb_reset_n_i) begin
        if (!sb_reset_n_i) begin
            r_tmo_pulse <= 1'b0;
            r_tmo_count <= '0;
        end else begin
            r_tmo_pulse <= w_timeout;
            if (w_timeout && (r_tmo_count != 8'hFF)) begin
                r_tmo_count <= r_tmo_count + 8'd1;
            end
        end
    end

    assign grant_o              = r_grant;
    assign active_master_o      = r_active;
    assign sb_end_transaction_o = r_tmo_pulse;
    assign sb_error_o           = r_tmo_pulse;
    assign busy_o               = (r_state != ST_IDLE);
    assign timeout_count_o      = r_tmo_count;
    assign dbg_state_o          = r_state;

endmodule

// File: tb/tb_sb_bus_arbiter.sv
// tb_sb_bus_arbiter: directed bench for sb_bus_arbiter. A transaction-level
// ownership model predicts every output on every cycle. Literal expectations
// pin grant order, latencies and timeout counts.
module tb_sb_bus_arbiter;

    localparam int N = 4;
    localparam int T = 200;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] req     = '0;
    logic       begin_i = 1'b0;
    logic       end_i   = 1'b0;
    logic       err_i   = 1'b0;

    logic [3:0] grant;
    logic [2:0] active;
    logic       end_o;
    logic       err_o;
    logic       busy;
    logic [7:0] tcount;
    logic [1:0] dbg_state;

    sb_bus_arbiter #(
        .NUM_MASTERS   (N),
        .TIMEOUT_WIDTH (8),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .sb_clock_i            (clk),
        .sb_reset_n_i          (rst_n),
        .request_i             (req),
        .sb_begin_transaction_i(begin_i),
        .sb_end_transaction_i  (end_i),
        .sb_error_i            (err_i),
        .grant_o               (grant),
        .active_master_o       (active),
        .sb_end_transaction_o  (end_o),
        .sb_error_o            (err_o),
        .busy_o                (busy),
        .timeout_count_o       (tcount),
        .dbg_state_o           (dbg_state)
    );

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Ownership view: owner < 0 means the bus is free. begun marks a started transaction.
    // age counts the cycles spent in the current phase.
    typedef struct packed {
        int   owner;
        logic begun;
        int   age;
        int   last;
        int   act;
        logic pulse;
        int   tcnt;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t s;
        s.owner = -1;
        s.begun = 1'b0;
        s.age   = 0;
        s.last  = N - 1;
        s.act   = 0;
        s.pulse = 1'b0;
        s.tcnt  = 0;
        return s;
    endfunction

    function automatic model_t model_next(model_t s, logic [3:0] r, logic b, logic e);
        model_t n;
        n       = s;
        n.pulse = 1'b0;
        if (s.owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = (s.last + k) % N;
                if (r[idx] && n.owner < 0) begin
                    n.owner = idx;
                    n.last  = idx;
                    n.act   = idx;
                    n.begun = 1'b0;
                    n.age   = 0;
                end
            end
        end else if (!s.begun) begin
            if (b) begin
                n.begun = 1'b1;
                n.age   = 0;
            end else if (!r[s.owner]) begin
                n.owner = -1;
            end else if (s.age == T - 1) begin
                n.owner = -1;
                n.pulse = 1'b1;
                n.tcnt  = (s.tcnt < 255) ? s.tcnt + 1 : 255;
            end else begin
                n.age = s.age + 1;
            end
        end else begin
            if (e) begin
                n.owner = -1;
            end else if (s.age == T - 1) begin
                n.owner = -1;
                n.pulse = 1'b1;
                n.tcnt  = (s.tcnt < 255) ? s.tcnt + 1 : 255;
            end else begin
                n.age = s.age + 1;
            end
        end
        return n;
    endfunction

    function automatic logic [17:0] model_outputs(model_t s);
        logic [3:0] g;
        g = (s.owner >= 0) ? 4'(1 << s.owner) : 4'b0;
        return {g, 3'(s.act), s.pulse, s.pulse, (s.owner >= 0), 8'(s.tcnt)};
    endfunction

    initial m = model_reset();

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= model_reset();
        else        m <= model_next(m, req, begin_i, end_i);
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("cycle_outputs", {14'b0, grant, active, end_o, err_o, busy, tcount}, {14'b0, model_outputs(m)});
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic wait_grant(output int n);
        n = 0;
        while (grant == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (grant == '0) begin
            errors++;
            $display("FAIL wait_grant: grant still 0 after %0d cycles, required nonzero", n);
        end
    endtask

    task automatic wait_end_pulse(output int n, input int limit);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!end_o && n < limit);
        checks++;
        if (!end_o) begin
            errors++;
            $display("FAIL wait_end_pulse: end_o 0 after %0d cycles, required 1", n);
        end
    endtask

    task automatic pulse_begin();
        begin_i = 1'b1;
        @(negedge clk);
        begin_i = 1'b0;
    endtask

    task automatic pulse_end(input logic [3:0] req_after);
        end_i = 1'b1;
        @(negedge clk);
        end_i = 1'b0;
        req   = req_after;
    endtask

    // ---------------- global time limit ----------------
    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1, "time limit");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int n;
        tick(3);
        check("reset_grant", grant, 4'b0000);
        check("reset_busy", busy, 1'b0);
        check("reset_tcount", tcount, 8'd0);
        check("reset_end_err", {end_o, err_o}, 2'b00);
        check("reset_state", dbg_state, 2'd0);
        rst_n = 1'b1;
        tick(1);

        // single master transaction, no error
        req = 4'b0001;
        wait_grant(n);
        check("t1_latency", n, 1);
        check("t1_grant", grant, 4'b0001);
        tick(2);
        pulse_begin();
        tick(7);
        pulse_end(4'b0000);
        check("t1_grant_cleared", grant, 4'b0000);
        check("t1_no_error", err_o, 1'b0);
        tick(2);

        // round robin with all masters requesting; reset restarts the pointer at master 0
        do_reset();
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0001);
        req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            wait_grant(n);
            check("rr_gap_cycles", n, 1);
            check("rr_order", grant, exp_q.pop_front());
            pulse_begin();
            tick(2);
            pulse_end((t == 4) ? 4'b0000 : 4'b1111);
            check("rr_idle_between", busy, 1'b0);
        end
        tick(2);

        // watchdog expiry in BUSY
        req = 4'b0100;
        wait_grant(n);
        check("to_active", active, 3'd2);
        pulse_begin();
        wait_end_pulse(n, 400);
        check("to_latency", n, T);
        check("to_err", err_o, 1'b1);
        check("to_grant_cleared", grant, 4'b0000);
        check("to_count1", tcount, 8'd1);
        req = 4'b0000;
        tick(1);
        check("to_pulse_width", end_o, 1'b0);
        tick(1);

        // request withdrawn before begin
        req = 4'b0010;
        wait_grant(n);
        check("wd_active", active, 3'd1);
        req = 4'b0000;
        tick(1);
        check("wd_grant", grant, 4'b0000);
        check("wd_busy", busy, 1'b0);
        tick(1);

        // slave end in the same cycle as expiry: slave wins
        req = 4'b0001;
        wait_grant(n);
        pulse_begin();
        tick(T - 1);
        end_i = 1'b1;
        req   = 4'b0000;
        tick(1);
        end_i = 1'b0;
        check("coll_end_o", {end_o, err_o}, 2'b00);
        check("coll_grant", grant, 4'b0000);
        check("coll_count", tcount, 8'd1);
        tick(1);

        // begin in the same cycle as expiry in GRANTED: begin wins
        req = 4'b0001;
        wait_grant(n);
        tick(T - 1);
        begin_i = 1'b1;
        tick(1);
        begin_i = 1'b0;
        check("bcoll_busy", busy, 1'b1);
        check("bcoll_end_o", end_o, 1'b0);
        check("bcoll_grant", grant, 4'b0001);
        tick(2);
        pulse_end(4'b0000);
        check("bcoll_release", grant, 4'b0000);

        // spurious strobes while IDLE
        end_i   = 1'b1;
        err_i   = 1'b1;
        begin_i = 1'b1;
        tick(1);
        end_i   = 1'b0;
        err_i   = 1'b0;
        begin_i = 1'b0;
        check("spur_grant", grant, 4'b0000);
        tick(2);

        // repeated expiries in GRANTED saturate the counter
        req = 4'b0100;
        for (int k = 0; k < 255; k++) begin
            wait_end_pulse(n, 500);
            if (k == 127) check("sat_mid_count", tcount, 8'd129);
        end
        check("sat_count", tcount, 8'd255);
        req = 4'b0000;
        tick(2);

        // asynchronous reset in the middle of BUSY
        req = 4'b0001;
        wait_grant(n);
        pulse_begin();
        tick(3);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_grant", grant, 4'b0000);
        check("areset_busy", busy, 1'b0);
        check("areset_end_err", {end_o, err_o}, 2'b00);
        check("areset_count", tcount, 8'd0);
        req = 4'b1000;
        @(negedge clk);
        rst_n = 1'b1;
        wait_grant(n);
        check("areset_regrant", grant, 4'b1000);
        check("areset_active", active, 3'd3);
        req = 4'b0000;
        tick(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sb_bus_arbiter.md
Name: sb_bus_arbiter

Overview:
- Arbitrates the shared OR'd system bus (sb_*) among NUM_MASTERS bus masters, e.g. the JTAG debug BIU, CPU instruction/data ports and DMA.
- Grants exactly one master per transaction using round-robin priority.
- Tracks the transaction until the slave ends it.
- Runs a watchdog that terminates hung transactions with a bus error, so the debug path never deadlocks the bus.

Parameters:
NUM_MASTERS, 4, number of requesters (2..8)
TIMEOUT_WIDTH, 8, width of watchdog counter
TIMEOUT_CYCLES, 200, cycles allowed in GRANTED or BUSY before forced release (1..2^TIMEOUT_WIDTH-1)

Ports:
sb_clock_i  in  1  system bus clock; all state on rising edge
sb_reset_n_i  in  1  asynchronous, active-low reset
request_i  in  NUM_MASTERS  per-master request; held until granted transaction completes
sb_begin_transaction_i  in  1  OR'd begin strobe from bus masters
sb_end_transaction_i  in  1  OR'd end strobe from slaves
sb_error_i  in  1  OR'd slave error, valid with end
grant_o  out  NUM_MASTERS  one-hot grant, registered
active_master_o  out  3  index of granted master (valid when grant_o != 0)
sb_end_transaction_o  out  1  arbiter-generated end on timeout; OR'd onto bus
sb_error_o  out  1  arbiter-generated error on timeout; OR'd onto bus
busy_o  out  1  high in GRANTED or BUSY
timeout_count_o  out  8  saturating count of watchdog expiries

Behaviour:
- Reset (sb_reset_n_i=0, asynchronous):
  - State is IDLE.
  - grant_o=0, active_master_o=0, sb_end_transaction_o=0, sb_error_o=0, busy_o=0, timeout_count_o=0.
  - Round-robin pointer last_q = NUM_MASTERS-1, so master 0 is first.
  - An in-flight transaction is abandoned; no end or error is generated.
- State IDLE:
  - If request_i != 0, the winner is the first set bit searching from last_q+1 upward, modulo NUM_MASTERS.
  - At the next edge: grant_o is the winner's one-hot, active_master_o = winner, last_q = winner, watchdog = 0, state moves to GRANTED.
  - Latency from request to grant: 1 cycle.
- State GRANTED:
  - sb_begin_transaction_i=1: next state BUSY, watchdog cleared.
  - Else if request_i[active] == 0 (request withdrawn): next state IDLE, grant_o cleared.
  - Else the watchdog increments.
- State BUSY:
  - sb_end_transaction_i=1: next state IDLE and grant_o cleared at the next edge. sb_error_i is ignored by the arbiter; the master consumes it.
  - Else the watchdog increments.
- Timeout (GRANTED or BUSY, watchdog == TIMEOUT_CYCLES-1 with no end/begin this cycle):
  - Next edge: sb_end_transaction_o=1 and sb_error_o=1 for exactly one cycle, grant_o cleared, state IDLE, timeout_count_o+1 (saturates at 255).
  - In GRANTED the generated end/error pulse still occurs; the master ignores it since it has not begun.
- Simultaneous events:
  - A slave end in the same cycle as expiry: the slave wins; no generated end/error; counter not incremented.
  - A begin in the same cycle as expiry in GRANTED: the begin wins; BUSY is entered with watchdog cleared.
- Spurious strobes: sb_end_transaction_i, sb_error_i or sb_begin_transaction_i in IDLE (and end in GRANTED) are ignored.
- Re-arbitration: every transaction is arbitrated separately.
  - End seen at edge t gives grant_o=0 from t+1; the next grant is visible at t+2.
  - A master holding request continuously yields to other requesters in round-robin order.
  - With a single requester, back-to-back transactions have one idle cycle between grants.
- Request bits of non-active masters may change at any time without effect until IDLE.
- grant_o is always one-hot or zero; it never changes within GRANTED or BUSY except on the exit transition.
- active_master_o holds its last value in IDLE.

Test Plan:
- Reset, request_i=4'b0001, begin 2 cycles after grant, end (32'hDEADBEEF on data) 8 cycles later -> grant_o=0001 1 cycle after request, cleared 1 cycle after end, no sb_error_o.
- request_i=4'b1111 held, each granted master does begin then end after 3 cycles -> grant order 0,1,2,3,0; busy_o low exactly 1 cycle between grants.
- request_i=4'b0100, begin, no end for TIMEOUT_CYCLES -> single-cycle sb_end_transaction_o=sb_error_o=1, grant_o cleared, timeout_count_o=1; repeat 256 times -> saturates at 255.
- Granted master 1 drops request before begin -> IDLE next edge. Separately, end and watchdog expiry in the same cycle -> no generated error, timeout_count_o unchanged.
- Assert sb_reset_n_i low mid-BUSY between clock edges -> grant_o, busy_o, sb_*_o low immediately. After release with request_i=1000 -> master 3 granted, pointer restarted.
